// File: rtl/irq_timer_bank_pkg.sv
// Shared definitions for the irq_timer_bank peripheral.
// Provides the per-channel register offsets, the CTRL bit indices, the
// global register offsets (relative to 4*NUM_CH) and the channel state type.
package irq_timer_bank_pkg;

  // Per-channel register offsets within the 4-word channel window.
  localparam int unsigned REG_RELOAD = 0;
  localparam int unsigned REG_CTRL   = 1;
  localparam int unsigned REG_COUNT  = 2;

  // CTRL register bit indices.
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  // Global register offsets, relative to 4*NUM_CH.
  localparam int unsigned PENDING_OFS  = 0;
  localparam int unsigned PRESCALE_OFS = 1;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/irq_timer_bank_timer_channel.sv
// One down-counting timer channel.
// Holds RELOAD, CTRL (EN is the IDLE/RUN state) and COUNT. On a prescaler
// tick while running it decrements COUNT, or expires when COUNT is already 0.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_tick             prescaler tick
//   i_we_reload        write strobe for RELOAD, data on i_wdata_reload
//   i_we_ctrl          write strobe for CTRL, data on i_wdata_ctrl
//   o_reload, o_count  current RELOAD and COUNT
//   o_ctrl             {IRQ_EN, PERIODIC, EN}
//   o_expire           one-cycle expiry pulse, consumed by the PENDING latch
module timer_channel
  import irq_timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_tick,
  input  logic             i_we_reload,
  input  logic             i_we_ctrl,
  input  logic [CNT_W-1:0] i_wdata_reload,
  input  logic [2:0]       i_wdata_ctrl,
  output logic [CNT_W-1:0] o_reload,
  output logic [CNT_W-1:0] o_count,
  output logic [2:0]       o_ctrl,
  output logic             o_expire
);

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_reload;
  logic [CNT_W-1:0] r_count;
  logic             r_periodic;
  logic             r_irq_en;

  // A CTRL write in the same cycle as a tick takes priority, so the tick
  // is neither counted nor allowed to expire the channel that cycle.
  assign o_expire = (r_state == CH_RUN) && i_tick && !i_we_ctrl && (r_count == '0);

  assign o_reload = r_reload;
  assign o_count  = r_count;
  assign o_ctrl   = {r_irq_en, r_periodic, (r_state == CH_RUN)};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= CH_IDLE;
      r_reload   <= '0;
      r_count    <= '0;
      r_periodic <= 1'b0;
      r_irq_en   <= 1'b0;
    end else begin
      if (i_we_reload) begin
        r_reload <= i_wdata_reload;
      end
      if (i_we_ctrl) begin
        r_periodic <= i_wdata_ctrl[CTRL_PERIODIC];
        r_irq_en   <= i_wdata_ctrl[CTRL_IRQ_EN];
        if (i_wdata_ctrl[CTRL_EN]) begin
          // Only the 0->1 transition reloads; re-enabling a running channel is a no-op.
          if (r_state == CH_IDLE) begin
            r_count <= r_reload;
            r_state <= CH_RUN;
          end
        end else begin
          r_state <= CH_IDLE;
        end
      end else if ((r_state == CH_RUN) && i_tick) begin
        // Expiry is checked before decrementing, so COUNT never wraps.
        if (r_count == '0) begin
          if (r_periodic) begin
            r_count <= r_reload;
          end else begin
            r_state <= CH_IDLE;
          end
        end else begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/irq_timer_bank.sv
// Multi-channel programmable timer / interrupt source on the CPU bus.
// Holds the shared prescaler, the PENDING latch, address decode and the
// registered read mux; NUM_CH timer_channel instances do the counting.
// Ports:
//   clk, reset  clock, synchronous active-low reset
//   addr        word-indexed register address
//   we, wdata   write strobe and data
//   re, rdata   read strobe and registered read data
//   irq         per-channel level interrupt, PENDING & IRQ_EN delayed one cycle
module irq_timer_bank
  import irq_timer_bank_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PRE_W  = 16,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic [NUM_CH-1:0] irq
);

  localparam int unsigned A_PENDING  = 4 * NUM_CH + PENDING_OFS;
  localparam int unsigned A_PRESCALE = 4 * NUM_CH + PRESCALE_OFS;

  logic [31:0]                  w_addr;
  logic                         w_tick;
  logic                         w_we_pre;
  logic [NUM_CH-1:0]            w_clr;
  logic [NUM_CH-1:0]            w_expire;
  logic [NUM_CH-1:0]            w_irq_en;
  logic [NUM_CH-1:0][CNT_W-1:0] w_reload;
  logic [NUM_CH-1:0][CNT_W-1:0] w_count;
  logic [NUM_CH-1:0][2:0]       w_ctrl;
  logic [15:0]                  w_rdata;

  logic [PRE_W-1:0]  r_prescale;
  logic [PRE_W-1:0]  r_pcnt;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_irq;
  logic [15:0]       r_rdata;

  assign w_addr   = 32'(addr);
  assign w_tick   = (r_pcnt == r_prescale);
  assign w_we_pre = we && (w_addr == A_PRESCALE);
  assign w_clr    = (we && (w_addr == A_PENDING)) ? wdata[NUM_CH-1:0] : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .i_clk          (clk),
      .i_reset_n      (reset),
      .i_tick         (w_tick),
      .i_we_reload    (we && (w_addr == 4 * g + REG_RELOAD)),
      .i_we_ctrl      (we && (w_addr == 4 * g + REG_CTRL)),
      .i_wdata_reload (wdata[CNT_W-1:0]),
      .i_wdata_ctrl   (wdata[2:0]),
      .o_reload       (w_reload[g]),
      .o_count        (w_count[g]),
      .o_ctrl         (w_ctrl[g]),
      .o_expire       (w_expire[g])
    );
    assign w_irq_en[g] = w_ctrl[g][CTRL_IRQ_EN];
  end

  // Reserved and unmapped addresses fall through to zero.
  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_addr == 4 * i + REG_RELOAD) w_rdata = 16'(w_reload[i]);
      if (w_addr == 4 * i + REG_CTRL)   w_rdata = 16'(w_ctrl[i]);
      if (w_addr == 4 * i + REG_COUNT)  w_rdata = 16'(w_count[i]);
    end
    if (w_addr == A_PENDING)  w_rdata = 16'(r_pending);
    if (w_addr == A_PRESCALE) w_rdata = 16'(r_prescale);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_pending  <= '0;
      r_irq      <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_we_pre) begin
        r_prescale <= wdata[PRE_W-1:0];
        r_pcnt     <= '0;
      end else if (w_tick) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
      // Expiry is OR-ed in after the clear so it wins a same-cycle W1C.
      r_pending <= (r_pending & ~w_clr) | w_expire;
      r_irq     <= r_pending & w_irq_en;
      if (re) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;

endmodule

// File: tb/tb_irq_timer_bank.sv
// Self-checking bench for irq_timer_bank (NUM_CH=8, CNT_W=16, PRE_W=16, ADDR_W=6).
module tb_irq_timer_bank;

  localparam logic [5:0] A_PEND = 6'd32;
  localparam logic [5:0] A_PRE  = 6'd33;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic [7:0]  irq;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] act_q[$];
  string       name_q[$];

  int unsigned rise_cyc[8];
  logic [7:0]  irq_d = '0;

  irq_timer_bank #(
    .NUM_CH(8),
    .CNT_W (16),
    .PRE_W (16),
    .ADDR_W(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .re   (re),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the edge index at which each irq line was last seen rising.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (irq[i] === 1'b1 && irq_d[i] !== 1'b1) rise_cyc[i] = cyc;
    end
    irq_d = irq;
  end

  function automatic logic [5:0] ca(input int ch, input int ofs);
    return 6'(4 * ch + ofs);
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] e, input string n);
    addr = a; re = 1'b1; we = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    re = 1'b0;
    act_q.push_back(rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] e, a;
    string n;
    reset = 1'b0; we = 1'b1; addr = 6'd0; wdata = 16'hFFFF;
    idle(2);
    reset = 1'b1; we = 1'b0;
    checks++;
    if (rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h want %h", rdata, 16'h0000); end
    checks++;
    if (irq !== 8'h00) begin errors++; $display("FAIL rst_irq: got %h want %h", irq, 8'h00); end
    rd(ca(0, 0), 16'h0000, "rst_reload0");
    rd(ca(0, 1), 16'h0000, "rst_ctrl0");
    rd(ca(0, 2), 16'h0000, "rst_count0");
    rd(A_PEND,   16'h0000, "rst_pending");
    rd(A_PRE,    16'h0000, "rst_prescale");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL %s: got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_regmap;
    logic [15:0] e, a;
    string n;
    wr(ca(3, 0), 16'hBEEF);
    wr(ca(3, 3), 16'hFFFF);
    wr(6'd40, 16'h1234);
    wr(ca(3, 2), 16'h5555);
    wr(A_PRE, 16'h0003);
    rd(ca(3, 0), 16'hBEEF, "reload3");
    rd(ca(3, 3), 16'h0000, "reserved3");
    rd(6'd40,    16'h0000, "unmapped40");
    rd(6'd63,    16'h0000, "unmapped63");
    rd(ca(3, 2), 16'h0000, "count3_ro");
    rd(A_PRE,    16'h0003, "prescale_rw");
    wr(ca(4, 0), 16'h1111);
    addr = ca(4, 0); wdata = 16'h2222; we = 1'b1; re = 1'b1;
    exp_q.push_back(16'h1111); name_q.push_back("wr_rd_same_cycle");
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    act_q.push_back(rdata);
    rd(ca(4, 0), 16'h2222, "reload4_new");
    wr(A_PRE, 16'h0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL %s: got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_oneshot;
    logic [15:0] e, a;
    string n;
    wr(ca(0, 0), 16'd3);
    wr(ca(0, 1), 16'b101);
    idle(3);
    rd(A_PEND, 16'h0000, "os_pend_before");
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL os_irq_early: got %b want 0", irq[0]); end
    rd(A_PEND, 16'h0001, "os_pend_set");
    checks++;
    if (irq[0] !== 1'b1) begin errors++; $display("FAIL os_irq_set: got %b want 1", irq[0]); end
    rd(ca(0, 1), 16'h0004, "os_ctrl_after");
    rd(ca(0, 2), 16'h0000, "os_count_after");
    wr(A_PEND, 16'h0001);
    idle(1);
    checks++;
    if (irq[0] !== 1'b0) begin errors++; $display("FAIL os_irq_cleared: got %b want 0", irq[0]); end
    rd(A_PEND, 16'h0000, "os_pend_cleared");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL %s: got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_periodic;
    logic [15:0] e, a;
    string n;
    int k;
    int unsigned t0, t1;
    wr(A_PRE, 16'd2);
    wr(ca(1, 0), 16'd1);
    wr(ca(1, 1), 16'b111);
    k = 0;
    while (irq[1] !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (irq[1] !== 1'b1) begin errors++; $display("FAIL per_first_irq: got %b want 1 (timeout)", irq[1]); end
    t0 = cyc;
    for (int p = 0; p < 2; p++) begin
      wr(A_PEND, 16'h0002);
      @(negedge clk);
      checks++;
      if (irq[1] !== 1'b0) begin errors++; $display("FAIL per_irq_cleared: got %b want 0", irq[1]); end
      k = 0;
      while (irq[1] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      t1 = cyc;
      checks++;
      if (irq[1] !== 1'b1 || t1 - t0 != 6) begin
        errors++; $display("FAIL per_period: got %0d cycles (irq=%b) want 6", t1 - t0, irq[1]);
      end
      t0 = t1;
    end
    wr(ca(1, 1), 16'h0000);
    wr(A_PEND, 16'h0002);
    wr(A_PRE, 16'h0000);
    idle(2);
    rd(A_PEND, 16'h0000, "per_pend_cleared");
    rd(ca(1, 1), 16'h0000, "per_ctrl_off");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL %s: got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_mask_race;
    logic [15:0] e, a;
    string n;
    wr(ca(2, 0), 16'd0);
    wr(ca(2, 1), 16'b011);
    idle(2);
    rd(A_PEND, 16'h0004, "mask_pend_set");
    checks++;
    if (irq !== 8'h00) begin errors++; $display("FAIL mask_irq_low: got %h want 00", irq); end
    wr(A_PEND, 16'h0004);
    rd(A_PEND, 16'h0004, "w1c_race_pend");
    wr(ca(2, 1), 16'h0000);
    rd(A_PEND, 16'h0004, "pend_after_stop");
    wr(ca(2, 1), 16'b100);
    idle(1);
    checks++;
    if (irq[2] !== 1'b1) begin errors++; $display("FAIL irqen_unmask: got %b want 1", irq[2]); end
    wr(ca(2, 1), 16'h0000);
    idle(1);
    checks++;
    if (irq[2] !== 1'b0) begin errors++; $display("FAIL irqen_mask: got %b want 0", irq[2]); end
    rd(A_PEND, 16'h0004, "pend_kept_masked");
    wr(A_PEND, 16'h0004);
    rd(A_PEND, 16'h0000, "mask_pend_clr");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL %s: got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_multi;
    logic [15:0] e, a;
    string n;
    int unsigned base;
    for (int i = 0; i < 8; i++) wr(ca(i, 0), 16'(i));
    for (int i = 0; i < 8; i++) rise_cyc[i] = 0;
    for (int i = 0; i < 8; i++) wr(ca(i, 1), 16'b101);
    base = cyc - 7;
    rd(ca(5, 2), 16'd3, "count5_first");
    rd(ca(5, 2), 16'd2, "count5_second");
    idle(12);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rise_cyc[i] != base + 2 * i + 2) begin
        errors++; $display("FAIL multi_irq_order ch%0d: got edge %0d want %0d", i, rise_cyc[i], base + 2 * i + 2);
      end
    end
    rd(A_PEND,   16'h00FF, "multi_pend_all");
    rd(ca(3, 1), 16'h0004, "multi_ctrl3_done");
    rd(ca(7, 2), 16'h0000, "multi_count7_zero");
    wr(A_PEND, 16'h00FF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL %s: got %h want %h", n, a, e); end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] e, a;
    string n;
    wr(ca(0, 0), 16'd2);
    rd(ca(0, 0), 16'd2, "mid_reload0");
    wr(ca(0, 1), 16'b101);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (rdata !== 16'h0000) begin errors++; $display("FAIL mid_rdata_rst: got %h want 0000", rdata); end
    rd(ca(0, 2), 16'h0000, "mid_count0");
    rd(ca(0, 1), 16'h0000, "mid_ctrl0");
    idle(6);
    checks++;
    if (irq !== 8'h00) begin errors++; $display("FAIL mid_irq: got %h want 00", irq); end
    rd(A_PEND, 16'h0000, "mid_pending");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n = name_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL %s: got %h want %h", n, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_regmap();
    test_oneshot();
    test_periodic();
    test_mask_race();
    test_multi();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_timer_bank.md
Name: irq_timer_bank

Overview:
- Parametrised multi-channel programmable timer and interrupt source; the successor to the single fixed timer that drives the CPU `interruptions` vector.
- Sits beside `i_o_manager` on the CPU address/data bus as a memory-mapped peripheral. Each channel counts prescaled ticks and raises a latched, maskable interrupt.
- Supports one-shot and periodic modes, a readable live count, and write-1-to-clear pending bits.

Parameters:
- NUM_CH, 8: number of timer channels, 1..8; drives `irq[NUM_CH-1:0]`.
- CNT_W, 16: channel counter/reload width, 1..16; reads are zero-extended to 16 bits.
- PRE_W, 16: prescaler width, 1..16.
- ADDR_W, 6: register address width; must satisfy 2^ADDR_W >= 4*NUM_CH+2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  ADDR_W  register address, word-indexed.
- we  in  1  write strobe; `wdata` is captured at the edge when `we`=1.
- re  in  1  read strobe.
- wdata  in  16  write data.
- rdata  out  16  read data, registered; the environment drives it onto the shared inout bus.
- irq  out  NUM_CH  per-channel interrupt, registered, level-high.

Behaviour:
- One clock domain; reset is synchronous and active-low. While reset=0 at a clock edge, every register goes to 0: reload, ctrl, count, pending, prescale, prescale counter, `rdata` and `irq`.
- Register map. Channel i uses addresses 4i+0 to 4i+3:
  - +0 RELOAD (RW, CNT_W bits).
  - +1 CTRL (RW): bit0 EN, bit1 PERIODIC, bit2 IRQ_EN.
  - +2 COUNT (RO).
  - +3 reserved: reads 0, writes ignored.
- Global registers:
  - 4*NUM_CH: PENDING (bits NUM_CH-1:0). Write 1 to clear; writing 0 has no effect.
  - 4*NUM_CH+1: PRESCALE (RW, PRE_W bits).
- Unmapped addresses read 0, and writes to them are ignored. Writes to RO registers are ignored.
- Read latency: `rdata` updates at the edge where `re`=1 and holds its value otherwise. If `we` and `re` are asserted together, the read returns the pre-write value.
- Prescaler:
  - The prescale counter increments every cycle.
  - When it equals PRESCALE, `tick`=1 for one cycle and the counter returns to 0. PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE resets the prescale counter to 0.
- Channel state machine, states IDLE (EN=0) and RUN (EN=1):
  - Write CTRL with EN 0->1: load COUNT=RELOAD and enter RUN. Writing EN=1 while already running does not reload.
  - RUN, tick, COUNT!=0: COUNT decrements by 1.
  - RUN, tick, COUNT==0 (expiry): set PENDING[i]. If PERIODIC=1, COUNT=RELOAD. If PERIODIC=0, EN is cleared to 0 (IDLE) and COUNT stays 0.
  - RELOAD=0 with PERIODIC=1: the channel expires on every tick.
  - Writing RELOAD while in RUN does not touch COUNT; it takes effect on the next reload.
  - Write EN=0: go to IDLE, freeze COUNT, leave PENDING unchanged.
- Arithmetic: COUNT never wraps below 0, because expiry is checked before decrementing.
- `irq[i]` at edge n+1 equals PENDING[i] & IRQ_EN[i] at edge n, giving a 1-cycle register delay. Clearing IRQ_EN masks `irq` without clearing PENDING.
- Simultaneous events:
  - A PENDING write-1-to-clear in the same cycle as an expiry of that channel: the expiry wins and PENDING stays 1.
  - A CTRL write in the same cycle as a tick: the write wins. EN 0->1 loads RELOAD and no decrement happens that cycle.
- Reset mid-count returns every channel to IDLE with COUNT=0 and no interrupt.

Decomposition:
- Shared package/include `irq_timer_defs`:
  - Register offsets: REG_RELOAD=0, REG_CTRL=1, REG_COUNT=2.
  - CTRL bit indices: EN=0, PERIODIC=1, IRQ_EN=2.
  - Global offsets: PENDING_OFS=0, PRESCALE_OFS=1, relative to 4*NUM_CH.
- One natural sub-module, `timer_channel` (CNT_W). It holds RELOAD/CTRL/COUNT, takes `tick`, write strobes and `wdata`, and outputs `count`, `ctrl` and `expire`. It is instantiated NUM_CH times in a generate loop. The top level holds the prescaler, PENDING, the address decode and the read mux.

Test Plan:
- Reset: hold reset=0 for 2 cycles with `we`=1 to addr 0 -> all reads return 0 and `irq`=0; the write is ignored.
- One-shot: PRESCALE=0, ch0 RELOAD=3, CTRL=0b101 -> PENDING[0] sets exactly 4 ticks after the enable edge and `irq[0]`=1 one cycle later. CTRL reads 0b100 afterwards and COUNT=0.
- Periodic with prescale: PRESCALE=2, ch1 RELOAD=1, CTRL=0b111 -> expiry every 6 clocks. Clear PENDING (write 0x0002) between expiries and observe `irq[1]` re-assert each period.
- Masking and W1C race: ch2 periodic with RELOAD=0 and IRQ_EN=0 -> PENDING[2]=1 while `irq[2]`=0. A W1C of 0x0004 in the same cycle as an expiry leaves PENDING[2]=1.
- Multi-channel: all NUM_CH channels with RELOAD=i and PRESCALE=0, enabled in the same write sequence -> PENDING bits set in order of i with the correct cycle offsets. Reading COUNT of ch5 mid-run returns the decrementing value one cycle after `re`.
- Reset mid-operation: assert reset=0 while ch0 has COUNT=2 -> after the edge COUNT=0 and EN=0. With reset released there is no expiry and `irq`=0.
